// File: rtl/jtframe_pocket_scaler_ctrl.sv
// ---------------------------------------------------------------------------
// jtframe_pocket_scaler_ctrl
//
// Sits between the Pocket video formatter and the APF video output. It
// measures the active frame geometry and tracks how many consecutive frames
// had the same geometry. It also picks a scaler slot, either forced from the
// OSD or derived from the locked geometry. When the slot has to change, it
// replaces one blanking pixel after vsync with an APF scaler-select command
// word. Every other pixel passes through with one pxl_cen of latency.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   pxl_cen        one-cycle strobe per Pocket pixel; all state advances on it
//   rotate         auto mode uses the upper half of the slot table
//   slot_force     [3] force enable, [2:0] forced slot index (taken mod SLOTS)
//   in_rgb/de/hs/vs  formatted video from the formatter
//   out_rgb/de/hs/vs video to the APF, delayed by one pixel
//   locked         geometry has been identical for STABLE frame compares
//   hsize, vsize   last locked active width / height
//   slot           slot currently programmed in the scaler
// ---------------------------------------------------------------------------
module jtframe_pocket_scaler_ctrl #(
  parameter int STABLE = 4,
  parameter int HW     = 10,
  parameter int VW     = 9,
  parameter int SLOTS  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          rotate,
  input  logic [3:0]    slot_force,
  input  logic [23:0]   in_rgb,
  input  logic          in_de,
  input  logic          in_hs,
  input  logic          in_vs,
  output logic [23:0]   out_rgb,
  output logic          out_de,
  output logic          out_hs,
  output logic          out_vs,
  output logic          locked,
  output logic [HW-1:0] hsize,
  output logic [VW-1:0] vsize,
  output logic [2:0]    slot
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARM    = 2'd1;
  localparam logic [1:0] WAITHS = 2'd2;
  localparam logic [1:0] SEND   = 2'd3;

  localparam logic [3:0]    STAB_MAX  = 4'(STABLE);
  localparam logic [2:0]    SLOT_MAX  = 3'(SLOTS - 1);
  localparam logic [2:0]    SLOT_HALF = 3'(SLOTS / 2);
  localparam logic [HW-1:0] H_ONE     = HW'(1);
  localparam logic [VW-1:0] V_ONE     = VW'(1);
  // Common width for comparing hsize against 2*vsize without truncation
  localparam int            CW        = ((HW > VW + 1) ? HW : VW + 1) + 1;

  logic [1:0]    state;
  logic [2:0]    pend;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] line_w;
  logic [VW-1:0] vcnt;
  logic [HW-1:0] prev_w;
  logic [VW-1:0] prev_h;
  logic [3:0]    stab;

  logic [HW-1:0] line_w_nx;
  logic [VW-1:0] vcnt_nx;
  logic          same_frame;
  logic [3:0]    stab_nx;
  logic          lock_nx;
  logic [HW-1:0] hsize_nx;
  logic [VW-1:0] vsize_nx;
  logic [CW-1:0] h_ext;
  logic [CW-1:0] v2_ext;
  logic          wide;
  logic [2:0]    base;
  logic [3:0]    auto_sum;
  logic [2:0]    force_mod;
  logic [2:0]    target;

  // Line close: hs is handled before vs, so a line ending on the vsync
  // pixel is still counted in the frame that vsync closes.
  always_comb begin
    line_w_nx = line_w;
    vcnt_nx   = vcnt;
    if (in_hs && (hcnt != '0)) begin
      line_w_nx = hcnt;
      vcnt_nx   = (vcnt == '1) ? vcnt : vcnt + V_ONE;
    end else begin
      line_w_nx = line_w;
      vcnt_nx   = vcnt;
    end
  end

  // Frame close: stability counter, lock flag and locked geometry as they
  // will be after the current vsync.
  always_comb begin
    same_frame = (line_w_nx == prev_w) && (vcnt_nx == prev_h);
    if (same_frame) begin
      stab_nx = (stab == STAB_MAX) ? stab : stab + 4'd1;
    end else begin
      stab_nx = 4'd0;
    end
    lock_nx = (stab_nx == STAB_MAX);
    if (lock_nx) begin
      hsize_nx = line_w_nx;
      vsize_nx = vcnt_nx;
    end else begin
      hsize_nx = hsize;
      vsize_nx = vsize;
    end
  end

  // Slot choice, based on the post-vsync lock state so the lock frame
  // itself can already request a change.
  always_comb begin
    h_ext     = CW'(hsize_nx);
    v2_ext    = CW'({vsize_nx, 1'b0});
    wide      = (h_ext > v2_ext);
    base      = rotate ? SLOT_HALF : 3'd0;
    auto_sum  = {1'b0, base} + {3'd0, wide};
    force_mod = 3'({29'd0, slot_force[2:0]} % SLOTS);
    target    = slot;
    if (slot_force[3]) begin
      target = force_mod;
    end else if (lock_nx) begin
      target = (auto_sum > {1'b0, SLOT_MAX}) ? SLOT_MAX : auto_sum[2:0];
    end else begin
      target = slot;
    end
  end

  // Video path: one pixel delay, command word replaces the SEND pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rgb <= 24'd0;
      out_de  <= 1'b0;
      out_hs  <= 1'b0;
      out_vs  <= 1'b0;
    end else if (pxl_cen) begin
      out_hs <= in_hs;
      out_vs <= in_vs;
      if (state == SEND) begin
        out_rgb <= {18'd0, pend, 3'b000};
        out_de  <= 1'b0;
      end else begin
        out_rgb <= in_rgb;
        out_de  <= in_de;
      end
    end
  end

  // Geometry measurement and stability tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt   <= '0;
      line_w <= '0;
      vcnt   <= '0;
      prev_w <= '0;
      prev_h <= '0;
      stab   <= 4'd0;
      locked <= 1'b0;
      hsize  <= '0;
      vsize  <= '0;
    end else if (pxl_cen) begin
      if (in_hs) begin
        hcnt <= '0;
      end else if (in_de && (hcnt != '1)) begin
        hcnt <= hcnt + H_ONE;
      end
      line_w <= line_w_nx;
      if (in_vs) begin
        prev_w <= line_w_nx;
        prev_h <= vcnt_nx;
        vcnt   <= '0;
        stab   <= stab_nx;
        locked <= lock_nx;
        hsize  <= hsize_nx;
        vsize  <= vsize_nx;
      end else begin
        vcnt <= vcnt_nx;
      end
    end
  end

  // Command sequencer: arm at vsync, wait for a blank hsync, send one word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= 3'd0;
      slot  <= 3'd0;
    end else if (pxl_cen) begin
      case (state)
        IDLE: begin
          if (in_vs && (target != slot)) begin
            pend  <= target;
            state <= ARM;
          end
        end
        ARM: begin
          // A new vsync before the hsync just refreshes the request
          if (in_vs) begin
            pend <= target;
          end else if (in_hs && !in_de) begin
            state <= WAITHS;
          end
        end
        WAITHS: begin
          if (in_vs) begin
            pend  <= target;
            state <= ARM;
          end else if (in_de) begin
            // Active video already started: drop it, retry next frame
            state <= IDLE;
          end else begin
            state <= SEND;
          end
        end
        SEND: begin
          slot  <= pend;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_pocket_scaler_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for jtframe_pocket_scaler_ctrl. Streams small synthetic frames:
//   A = 24x16 (auto slot offset 0), B = 40x12 (auto slot offset 1),
//   C = 20x16 (used to break stability).
// A monitor compares every output pixel against the input delayed by one
// pxl_cen. Pixels that differ in rgb are treated as command words and logged.
// Blank pixels carry BLANK, and active pixels have bit 23 set, so a command
// word can never match the pixel it replaces.
// ---------------------------------------------------------------------------
module tb_jtframe_pocket_scaler_ctrl;

  localparam logic [23:0] BLANK = 24'hA5A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pxl_cen = 1'b0;
  logic        rotate = 1'b0;
  logic [3:0]  slot_force = 4'd0;
  logic [23:0] in_rgb = 24'd0;
  logic        in_de = 1'b0;
  logic        in_hs = 1'b0;
  logic        in_vs = 1'b0;
  logic [23:0] out_rgb;
  logic        out_de, out_hs, out_vs, locked;
  logic [9:0]  hsize;
  logic [8:0]  vsize;
  logic [2:0]  slot;

  int total = 0;
  int bad = 0;

  jtframe_pocket_scaler_ctrl #(.STABLE(4), .HW(10), .VW(9), .SLOTS(4)) dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .rotate(rotate),
    .slot_force(slot_force), .in_rgb(in_rgb), .in_de(in_de), .in_hs(in_hs),
    .in_vs(in_vs), .out_rgb(out_rgb), .out_de(out_de), .out_hs(out_hs),
    .out_vs(out_vs), .locked(locked), .hsize(hsize), .vsize(vsize), .slot(slot)
  );

  always #5 clk = ~clk;

  // Pass-through reference and command logger
  logic [23:0] exp_rgb;
  logic        exp_de, exp_hs, exp_vs, fresh;
  int          cmd_count = 0;
  int          pt_err = 0;
  logic [23:0] last_cmd = 24'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_rgb <= 24'd0; exp_de <= 1'b0; exp_hs <= 1'b0; exp_vs <= 1'b0;
      fresh <= 1'b0;
    end else begin
      fresh <= pxl_cen;
      if (pxl_cen) begin
        exp_rgb <= in_rgb; exp_de <= in_de; exp_hs <= in_hs; exp_vs <= in_vs;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && fresh) begin
      if (out_hs !== exp_hs || out_vs !== exp_vs) pt_err <= pt_err + 1;
      if (out_rgb !== exp_rgb) begin
        cmd_count <= cmd_count + 1;
        last_cmd  <= out_rgb;
        if (out_de !== 1'b0 || exp_de !== 1'b0) pt_err <= pt_err + 1;
      end else if (out_de !== exp_de) begin
        pt_err <= pt_err + 1;
      end
    end
  end

  task automatic pix(input logic [23:0] rgb, input logic de, input logic hs, input logic vs);
    @(negedge clk);
    in_rgb = rgb; in_de = de; in_hs = hs; in_vs = vs; pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
  endtask

  task automatic blanks(input int n);
    for (int i = 0; i < n; i++) pix(BLANK, 1'b0, 1'b0, 1'b0);
  endtask

  // Leading blank line (skipped when abort=1, so de follows the first hs
  // immediately), h active lines of w pixels, closing hs, then vsync.
  task automatic frame(input int w, input int h, input bit abort);
    if (!abort) begin
      pix(BLANK, 1'b0, 1'b1, 1'b0);
      blanks(4);
    end
    for (int l = 0; l < h; l++) begin
      pix(BLANK, 1'b0, 1'b1, 1'b0);
      if (!(abort && l == 0)) blanks(1);
      for (int p = 0; p < w; p++) pix(24'h800000 | 24'($urandom), 1'b1, 1'b0, 1'b0);
      blanks(2);
    end
    pix(BLANK, 1'b0, 1'b1, 1'b0);
    blanks(2);
    pix(BLANK, 1'b0, 1'b0, 1'b1);
    blanks(1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({out_rgb, out_de, out_hs, out_vs, locked, hsize, vsize, slot} !== 52'd0) begin
      bad++;
      $display("FAIL reset_outputs: rgb=%h de=%b hs=%b vs=%b lk=%b h=%0d v=%0d slot=%0d want all 0",
               out_rgb, out_de, out_hs, out_vs, locked, hsize, vsize, slot);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    for (int f = 0; f < 4; f++) frame(24, 16, 1'b0);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL lock_after_4vs: locked=%b want 0", locked); end
    frame(24, 16, 1'b0);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL lock_after_5vs: locked=%b want 1", locked); end
    total++;
    if (hsize !== 10'd24 || vsize !== 9'd16) begin
      bad++; $display("FAIL lock_size: hsize=%0d vsize=%0d want 24 16", hsize, vsize);
    end
    frame(24, 16, 1'b0);
    total++;
    if (cmd_count !== 0 || slot !== 3'd0) begin
      bad++; $display("FAIL lock_no_cmd: cmds=%0d slot=%0d want 0 0", cmd_count, slot);
    end
  endtask

  task automatic test_rotate();
    rotate = 1'b1;
    frame(24, 16, 1'b0);
    total++;
    if (cmd_count !== 0) begin bad++; $display("FAIL rot_armed_only: cmds=%0d want 0", cmd_count); end
    frame(24, 16, 1'b0);
    total++;
    if (cmd_count !== 1 || last_cmd !== 24'h000010) begin
      bad++; $display("FAIL rot_cmd: cmds=%0d word=%h want 1 000010", cmd_count, last_cmd);
    end
    total++;
    if (slot !== 3'd2) begin bad++; $display("FAIL rot_slot: slot=%0d want 2", slot); end
    frame(24, 16, 1'b0);
    total++;
    if (cmd_count !== 1 || locked !== 1'b1) begin
      bad++; $display("FAIL rot_single: cmds=%0d locked=%b want 1 1", cmd_count, locked);
    end
  endtask

  task automatic test_unstable();
    rotate = 1'b0;
    for (int f = 0; f < 6; f++) begin
      frame((f % 2 == 0) ? 20 : 24, 16, 1'b0);
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL unst_locked_%0d: locked=%b want 0", f, locked); end
    end
    total++;
    if (hsize !== 10'd24 || vsize !== 9'd16 || slot !== 3'd2) begin
      bad++; $display("FAIL unst_hold: hsize=%0d vsize=%0d slot=%0d want 24 16 2", hsize, vsize, slot);
    end
    total++;
    if (cmd_count !== 1 || pt_err !== 0) begin
      bad++; $display("FAIL unst_passthru: cmds=%0d pt_err=%0d want 1 0", cmd_count, pt_err);
    end
  endtask

  task automatic test_force();
    slot_force = 4'b1011;
    frame(24, 16, 1'b0);
    frame(24, 16, 1'b0);
    total++;
    if (cmd_count !== 2 || last_cmd !== 24'h000018) begin
      bad++; $display("FAIL force_cmd: cmds=%0d word=%h want 2 000018", cmd_count, last_cmd);
    end
    total++;
    if (slot !== 3'd3 || locked !== 1'b0) begin
      bad++; $display("FAIL force_slot: slot=%0d locked=%b want 3 0", slot, locked);
    end
    slot_force = 4'b0000;
    for (int f = 0; f < 3; f++) frame(24, 16, 1'b0);
    total++;
    if (cmd_count !== 3 || last_cmd !== 24'h000000) begin
      bad++; $display("FAIL unforce_cmd: cmds=%0d word=%h want 3 000000", cmd_count, last_cmd);
    end
    total++;
    if (slot !== 3'd0 || locked !== 1'b1) begin
      bad++; $display("FAIL unforce_slot: slot=%0d locked=%b want 0 1", slot, locked);
    end
  endtask

  task automatic test_abort();
    for (int f = 0; f < 5; f++) frame(40, 12, 1'b0);
    frame(40, 12, 1'b1);
    total++;
    if (cmd_count !== 3 || slot !== 3'd0) begin
      bad++; $display("FAIL abort_nocmd: cmds=%0d slot=%0d want 3 0", cmd_count, slot);
    end
    total++;
    if (locked !== 1'b1 || hsize !== 10'd40 || vsize !== 9'd12) begin
      bad++; $display("FAIL abort_geom: locked=%b hsize=%0d vsize=%0d want 1 40 12", locked, hsize, vsize);
    end
    frame(40, 12, 1'b0);
    total++;
    if (cmd_count !== 4 || last_cmd !== 24'h000008 || slot !== 3'd1) begin
      bad++; $display("FAIL abort_retry: cmds=%0d word=%h slot=%0d want 4 000008 1", cmd_count, last_cmd, slot);
    end
  endtask

  task automatic test_async_reset();
    slot_force = 4'b1110;
    frame(40, 12, 1'b0);
    frame(40, 12, 1'b0);
    total++;
    if (cmd_count !== 5 || last_cmd !== 24'h000010 || slot !== 3'd2) begin
      bad++; $display("FAIL force_mod: cmds=%0d word=%h slot=%0d want 5 000010 2", cmd_count, last_cmd, slot);
    end
    slot_force = 4'b1011;
    frame(40, 12, 1'b0);
    pix(BLANK, 1'b0, 1'b1, 1'b0);
    total++;
    if (locked !== 1'b1 || out_hs !== 1'b1) begin
      bad++; $display("FAIL pre_reset: locked=%b out_hs=%b want 1 1", locked, out_hs);
    end
    @(negedge clk);
    in_rgb = BLANK; in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0; pxl_cen = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({out_rgb, out_de, out_hs, out_vs, locked, hsize, vsize, slot} !== 52'd0) begin
      bad++;
      $display("FAIL async_reset: rgb=%h de=%b hs=%b vs=%b lk=%b h=%0d v=%0d slot=%0d want all 0",
               out_rgb, out_de, out_hs, out_vs, locked, hsize, vsize, slot);
    end
    @(negedge clk);
    pxl_cen = 1'b0;
    slot_force = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int f = 0; f < 4; f++) frame(24, 16, 1'b0);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL relock_4vs: locked=%b want 0", locked); end
    frame(24, 16, 1'b0);
    total++;
    if (locked !== 1'b1 || hsize !== 10'd24 || vsize !== 9'd16 || slot !== 3'd0) begin
      bad++; $display("FAIL relock_5vs: locked=%b hsize=%0d vsize=%0d slot=%0d want 1 24 16 0",
                      locked, hsize, vsize, slot);
    end
    blanks(2);
    total++;
    if (cmd_count !== 5 || pt_err !== 0) begin
      bad++; $display("FAIL final_passthru: cmds=%0d pt_err=%0d want 5 0", cmd_count, pt_err);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_rotate();
    test_unstable();
    test_force();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
